// File: rtl/uart_axil_pkg.sv
// Shared register map, bit positions, response codes and control layout
// for the UART AXI-Lite register block.
package uart_axil_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_BAUD   = 2'd3;

  localparam int ST_RX_EMPTY     = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_TX_FULL      = 3;
  localparam int ST_OVERRUN      = 4;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  localparam int CTRL_CLR_OVR = 4;
  localparam int CTRL_FLUSH   = 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic irq_tx_en;
    logic irq_rx_en;
    logic rx_en;
    logic tx_en;
  } ctrl_t;

endpackage

// File: rtl/uart_axil_regs_fifo.sv
// First-word-fall-through synchronous FIFO with single-cycle flush.
// The head is read combinationally so a pop sees its data in the same cycle.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        we,
  input  logic [DATA_WIDTH-1:0]       wd,
  input  logic                        re,
  output logic [DATA_WIDTH-1:0]       rd,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  input  logic                        flush
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  push;
  logic                  pop;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign pop  = re && !empty && !flush;
  assign push = we && (!full || pop) && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wd;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign rd    = mem[rd_ptr_reg];
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/uart_axil_regs.sv
// AXI4-Lite register front end for a UART: RX/TX FIFOs, baud divisor,
// control enables, sticky overrun and a registered level interrupt.
module uart_axil_regs
  import uart_axil_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int RX_DEPTH    = 16,
  parameter int TX_DEPTH    = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [3:0]            s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [3:0]            s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ready,
  output logic [DIV_WIDTH-1:0]  baud_div,
  output logic                  rx_en_o,
  output logic                  tx_en_o,
  output logic                  irq
);

  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic                 awready_reg, wready_reg, bvalid_reg;
  logic [1:0]           bresp_reg;
  logic [1:0]           awaddr_reg;
  logic [31:0]          wdata_reg;
  logic [3:0]           wstrb_reg;
  logic                 arready_reg, rvalid_reg;
  logic [31:0]          rdata_reg;
  ctrl_t                ctrl_reg;
  logic [DIV_WIDTH-1:0] baud_reg, baud_next;
  logic                 overrun_reg, irq_reg;

  logic                  rx_full, rx_empty, tx_full, tx_empty;
  logic [RX_CW-1:0]      rx_count;
  logic [TX_CW-1:0]      tx_count;
  logic [DATA_WIDTH-1:0] rx_head;
  logic                  rx_we, rx_re, tx_we, tx_re;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  do_write, wr_data, wr_ctrl, wr_baud;
  logic                  flush, clr_ovr, rx_accept, ovr_set;
  logic [1:0]            wr_resp;
  logic [31:0]           status_word, rd_value;
  logic                  unused_bits;

  assign aw_hs = s_axi_awvalid && awready_reg;
  assign w_hs  = s_axi_wvalid && wready_reg;
  assign b_hs  = bvalid_reg && s_axi_bready;
  assign ar_hs = s_axi_arvalid && arready_reg;
  assign r_hs  = rvalid_reg && s_axi_rready;

  // Both halves of the write are held and no response is outstanding.
  assign do_write = !awready_reg && !wready_reg && !bvalid_reg;
  assign wr_data  = do_write && (awaddr_reg == ADDR_DATA) && wstrb_reg[0];
  assign wr_ctrl  = do_write && (awaddr_reg == ADDR_CTRL) && wstrb_reg[0];
  assign wr_baud  = do_write && (awaddr_reg == ADDR_BAUD);
  assign flush    = wr_ctrl && wdata_reg[CTRL_FLUSH];
  assign clr_ovr  = wr_ctrl && wdata_reg[CTRL_CLR_OVR];

  // TX full is judged before any drain in the same cycle.
  assign tx_we = wr_data && !tx_full;
  assign tx_re = tx_valid && tx_ready;

  assign rx_re     = ar_hs && (s_axi_araddr[3:2] == ADDR_DATA);
  assign rx_accept = rx_valid && ctrl_reg.rx_en;
  assign rx_we     = rx_accept;
  assign ovr_set   = rx_accept && rx_full && !(rx_re && !rx_empty);

  for (genvar gi = 0; gi < DIV_WIDTH; gi++) begin : g_baud
    assign baud_next[gi] = (wr_baud && wstrb_reg[gi/8]) ? wdata_reg[gi] : baud_reg[gi];
  end

  always_comb begin
    wr_resp = RESP_OKAY;
    if (awaddr_reg == ADDR_STATUS) begin
      wr_resp = RESP_SLVERR;
    end else if ((awaddr_reg == ADDR_DATA) && wstrb_reg[0] && tx_full) begin
      wr_resp = RESP_SLVERR;
    end
  end

  always_comb begin
    status_word                          = '0;
    status_word[ST_RX_EMPTY]             = rx_empty;
    status_word[ST_RX_FULL]              = rx_full;
    status_word[ST_TX_EMPTY]             = tx_empty;
    status_word[ST_TX_FULL]              = tx_full;
    status_word[ST_OVERRUN]              = overrun_reg;
    status_word[ST_RX_COUNT_LSB +: 8]    = 8'(rx_count);
    status_word[ST_TX_COUNT_LSB +: 8]    = 8'(tx_count);
  end

  always_comb begin
    rd_value = '0;
    case (s_axi_araddr[3:2])
      ADDR_DATA:   rd_value = rx_empty ? 32'd0 : (32'h8000_0000 | 32'(rx_head));
      ADDR_STATUS: rd_value = status_word;
      ADDR_CTRL:   rd_value = 32'(ctrl_reg);
      default:     rd_value = 32'(baud_reg);
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      awready_reg <= 1'b1;
      wready_reg  <= 1'b1;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      arready_reg <= 1'b1;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      ctrl_reg    <= '0;
      baud_reg    <= DIV_WIDTH'(DEFAULT_DIV);
      overrun_reg <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      if (aw_hs) begin
        awready_reg <= 1'b0;
        awaddr_reg  <= s_axi_awaddr[3:2];
      end
      if (w_hs) begin
        wready_reg <= 1'b0;
        wdata_reg  <= s_axi_wdata;
        wstrb_reg  <= s_axi_wstrb;
      end
      if (do_write) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= wr_resp;
      end
      if (b_hs) begin
        bvalid_reg  <= 1'b0;
        awready_reg <= 1'b1;
        wready_reg  <= 1'b1;
      end
      if (wr_ctrl) ctrl_reg <= ctrl_t'(wdata_reg[3:0]);
      baud_reg <= baud_next;
      // A fresh overrun beats a clear requested in the same cycle.
      if (ovr_set)      overrun_reg <= 1'b1;
      else if (clr_ovr) overrun_reg <= 1'b0;
      if (ar_hs) begin
        arready_reg <= 1'b0;
        rvalid_reg  <= 1'b1;
        rdata_reg   <= rd_value;
      end
      if (r_hs) begin
        rvalid_reg  <= 1'b0;
        arready_reg <= 1'b1;
      end
      irq_reg <= (ctrl_reg.irq_rx_en && !rx_empty) ||
                 (ctrl_reg.irq_tx_en && tx_empty) || overrun_reg;
    end
  end

  sync_fifo_fwft #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .we(rx_we), .wd(rx_data), .re(rx_re), .rd(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_count), .flush(flush)
  );

  sync_fifo_fwft #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .we(tx_we), .wd(wdata_reg[DATA_WIDTH-1:0]), .re(tx_re),
    .rd(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count), .flush(flush)
  );

  assign s_axi_awready = awready_reg;
  assign s_axi_wready  = wready_reg;
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = bresp_reg;
  assign s_axi_arready = arready_reg;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = RESP_OKAY;
  assign tx_valid      = ctrl_reg.tx_en && !tx_empty;
  assign baud_div      = baud_reg;
  assign rx_en_o       = ctrl_reg.rx_en;
  assign tx_en_o       = ctrl_reg.tx_en;
  assign irq           = irq_reg;

  assign unused_bits = ^{wdata_reg, wstrb_reg, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_uart_axil_regs.sv
// Self-checking bench for uart_axil_regs: directed scenarios plus a random
// operation mix compared against a queue-based model of the register block.
module tb_uart_axil_regs;

  localparam int DW   = 8;
  localparam int RXD  = 16;
  localparam int TXD  = 16;
  localparam int DIVW = 16;

  logic            clk, resetn;
  logic [3:0]      awaddr, araddr, wstrb;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [31:0]     wdata, rdata;
  logic [1:0]      bresp, rresp;
  logic            rx_valid, tx_valid, tx_ready, rx_en_o, tx_en_o, irq;
  logic [DW-1:0]   rx_data, tx_data;
  logic [DIVW-1:0] baud_div;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [3:0]  m_ctrl;
  logic [15:0] m_baud;
  logic        m_ovr;

  uart_axil_regs #(.DATA_WIDTH(DW), .RX_DEPTH(RXD), .TX_DEPTH(TXD),
                   .DIV_WIDTH(DIVW), .DEFAULT_DIV(868)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .baud_div(baud_div), .rx_en_o(rx_en_o), .tx_en_o(tx_en_o), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s      = '0;
    s[0]   = (rx_q.size() == 0);
    s[1]   = (rx_q.size() == RXD);
    s[2]   = (tx_q.size() == 0);
    s[3]   = (tx_q.size() == TXD);
    s[4]   = m_ovr;
    s[15:8]  = 8'(rx_q.size());
    s[23:16] = 8'(tx_q.size());
    return s;
  endfunction

  function automatic logic exp_irq();
    return (m_ctrl[2] && rx_q.size() > 0) || (m_ctrl[3] && tx_q.size() == 0) || m_ovr;
  endfunction

  function automatic logic [1:0] model_write(input logic [3:0] a, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [1:0] r;
    r = 2'b00;
    case (a[3:2])
      2'd0: if (s[0]) begin
        if (tx_q.size() >= TXD) r = 2'b10;
        else tx_q.push_back(d[7:0]);
      end
      2'd1: r = 2'b10;
      2'd2: if (s[0]) begin
        m_ctrl = d[3:0];
        if (d[4]) m_ovr = 1'b0;
        if (d[5]) begin
          rx_q.delete();
          tx_q.delete();
        end
      end
      default: for (int b = 0; b < 2; b++) if (s[b]) m_baud[b*8 +: 8] = d[b*8 +: 8];
    endcase
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] v;
    case (a[3:2])
      2'd0:    v = (rx_q.size() > 0) ? (32'h8000_0000 | 32'(rx_q.pop_front())) : 32'd0;
      2'd1:    v = exp_status();
      2'd2:    v = 32'(m_ctrl);
      default: v = 32'(m_baud);
    endcase
    return v;
  endfunction

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    logic aw_acc, w_acc;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_acc) awvalid = 1'b0;
      if (w_acc)  wvalid  = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    while (!bvalid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("wr_bvalid", 32'(bvalid), 32'd1);
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    logic acc;
    araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0;
    while (arvalid && n < 50) begin
      acc = arready;
      @(posedge clk); #1;
      if (acc) arvalid = 1'b0;
      n++;
    end
    arvalid = 1'b0;
    while (!rvalid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rd_rvalid", 32'(rvalid), 32'd1);
    d = rdata;
    r = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    logic [1:0] e, r;
    e = model_write(a, d, s);
    axi_write(a, d, s, r);
    $display("WR %s addr=%0h data=%08h strb=%0h bresp=%0d", tag, a, d, s, r);
    check(tag, 32'(r), 32'(e));
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a);
    logic [31:0] e, d;
    logic [1:0]  r;
    e = model_read(a);
    axi_read(a, d, r);
    $display("RD %s addr=%0h data=%08h rresp=%0d", tag, a, d, r);
    check(tag, d, e);
    check({tag, "_resp"}, 32'(r), 32'd0);
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    if (m_ctrl[1]) begin
      if (rx_q.size() < RXD) rx_q.push_back(d);
      else m_ovr = 1'b1;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    $display("RX push data=%02h", d);
  endtask

  task automatic check_side();
    logic exp_tv;
    @(posedge clk); #1;
    exp_tv = m_ctrl[0] && (tx_q.size() > 0);
    check("irq", 32'(irq), 32'(exp_irq()));
    check("tx_valid", 32'(tx_valid), 32'(exp_tv));
    if (exp_tv) check("tx_data", 32'(tx_data), 32'(tx_q[0]));
    check("baud_div", 32'(baud_div), 32'(m_baud));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  obs [2];
    logic [31:0] rnd;
    logic [1:0]  e;
    int k, n, op;

    resetn = 1'b0; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0; rx_valid = 0; rx_data = '0; tx_ready = 0;
    m_ctrl = '0; m_baud = 16'd868; m_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_enables", 32'({rx_en_o, tx_en_o}), 32'd0);
    check("rst_baud", 32'(baud_div), 32'd868);

    rd_chk("rd_baud_rst", 4'hC);
    rd_chk("rd_status_rst", 4'h4);
    wr_chk("wr_baud_lane1", 4'hC, 32'h0000_1234, 4'b0010);
    rd_chk("rd_baud_lane1", 4'hC);
    wr_chk("wr_status", 4'h4, 32'hFFFF_FFFF, 4'hF);

    // TX path: queue two characters then drain on consecutive handshakes.
    wr_chk("wr_ctrl3", 4'h8, 32'h3, 4'hF);
    check("en_out", 32'({rx_en_o, tx_en_o}), 32'd3);
    wr_chk("wr_tx41", 4'h0, 32'h41, 4'hF);
    wr_chk("wr_tx42", 4'h0, 32'h42, 4'hF);
    check_side();
    tx_ready = 1'b1; k = 0; n = 0;
    while (k < 2 && n < 20) begin
      if (tx_valid) begin
        obs[k] = tx_data;
        k++;
      end
      @(posedge clk); #1;
      n++;
    end
    tx_ready = 1'b0;
    check("tx_drain_cnt", 32'(k), 32'd2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("tx_drain%0d", i), 32'(obs[i]), 32'(tx_q.pop_front()));
      $display("TX char=%02h", obs[i]);
    end
    rd_chk("rd_status_txe", 4'h4);

    // RX overflow: 17 characters into a 16-deep FIFO.
    for (int i = 0; i <= 16; i++) rx_push(8'(i));
    check_side();
    rd_chk("rd_status_ovr", 4'h4);
    for (int i = 0; i <= 16; i++) rd_chk($sformatf("rx_rd%0d", i), 4'h0);
    wr_chk("wr_clr_ovr", 4'h8, 32'h13, 4'hF);
    check_side();

    // TX full: 17 writes with the transmitter disabled.
    wr_chk("wr_ctrl2", 4'h8, 32'h2, 4'hF);
    for (int i = 0; i <= 16; i++) wr_chk($sformatf("tx_fill%0d", i), 4'h0, $urandom, 4'h1);
    rd_chk("rd_status_txfull", 4'h4);
    check_side();

    // AW three cycles ahead of W, B held off for four cycles.
    wr_chk("wr_flush", 4'h8, 32'h22, 4'hF);
    e = model_write(4'h0, 32'h5A, 4'h1);
    awaddr = 4'h0; awvalid = 1'b1; wdata = 32'h5A; wstrb = 4'h1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("aw_held", 32'(awready), 32'd0);
    repeat (2) @(posedge clk);
    #1 wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("w_held", 32'(wready), 32'd0);
    check("b_not_early", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_hold%0d", i), 32'({bvalid, bresp}), 32'({1'b1, e}));
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("b_done", 32'({bvalid, awready, wready}), 32'b011);
    $display("WR slow data=5a bresp=%0d", e);
    rd_chk("rd_status_single", 4'h4);

    // Interrupt latency and flush.
    wr_chk("wr_irq_rx", 4'h8, 32'h6, 4'hF);
    check_side();
    rx_push(8'h77);
    check("irq_lag", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("irq_set", 32'(irq), 32'd1);
    wr_chk("wr_flush_irq", 4'h8, 32'h26, 4'hF);
    check("irq_flush", 32'(irq), 32'd0);
    rd_chk("rd_status_flush", 4'h4);

    // Clear-overrun write committing in the same cycle as a new overrun.
    for (int i = 0; i < RXD; i++) rx_push(8'($urandom));
    e = model_write(4'h8, 32'h16, 4'hF);
    m_ovr = 1'b1;
    awaddr = 4'h8; wdata = 32'h16; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; rx_valid = 1'b1; rx_data = 8'h99;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("clr_commit", 32'({bvalid, bresp}), 32'({1'b1, e}));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    rd_chk("rd_status_ovr_wins", 4'h4);
    check_side();

    // Random mix against the model; transmitter never drains here.
    wr_chk("wr_rand_start", 4'h8, 32'h22, 4'hF);
    for (int it = 0; it < 120; it++) begin
      op = $urandom_range(0, 6);
      rnd = $urandom;
      case (op)
        0, 1: rx_push(rnd[7:0]);
        2: rd_chk("r_rd_data", 4'h0);
        3: wr_chk("r_wr_data", 4'h0, rnd, 4'hF);
        4: rd_chk("r_rd_status", 4'h4);
        5: wr_chk("r_wr_ctrl", 4'h8,
                  {26'd0, (rnd[10:8] == 3'd0), rnd[4], rnd[3:1], rnd[0] & rnd[12]}, 4'hF);
        default: wr_chk("r_wr_baud", 4'hC, rnd, rnd[19:16]);
      endcase
      check_side();
    end
    rd_chk("rd_ctrl_final", 4'h8);
    rd_chk("rd_baud_final", 4'hC);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
